// File: rtl/store_queue_responder.sv
// Store-queue responder for the load/store FU request/response interface.
// Allocates store entries at dispatch, captures store address/data from the
// FU, answers loads by forwarding or a memory read, and drains committed
// stores to memory in program order over one shared memory port.
// Optional feature: define SQ_FORWARD_EN to enable store-to-load forwarding.
// Without it, a load that matches an older store waits for that store to drain.
module store_queue_responder #(
  parameter int SQ_DEPTH = 8,
  parameter int XLEN     = 32,
  parameter int IDX_W    = $clog2(SQ_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dispatch_en,
  output logic [IDX_W-1:0] sq_tail,
  output logic             sq_full,
  input  logic             fu_valid,
  input  logic             fu_load,
  input  logic             fu_store,
  input  logic [XLEN-1:0]  fu_addr,
  input  logic [XLEN-1:0]  fu_value,
  input  logic [IDX_W-1:0] fu_sq_pos,
  output logic             lsq_valid,
  output logic [XLEN-1:0]  lsq_value,
  input  logic             commit_store,
  input  logic             squash,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_grant,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SQ_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST_REQ,
    S_LD_REQ,
    S_LD_WAIT,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] commit_q, commit_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [SQ_DEPTH-1:0] valid_q, valid_d;
  logic [SQ_DEPTH-1:0] addr_valid_q, addr_valid_d;
  logic [SQ_DEPTH-1:0] committed_q, committed_d;
  logic [XLEN-1:0]     addr_q [SQ_DEPTH];
  logic [XLEN-1:0]     addr_d [SQ_DEPTH];
  logic [XLEN-1:0]     data_q [SQ_DEPTH];
  logic [XLEN-1:0]     data_d [SQ_DEPTH];

  logic [XLEN-1:0] ld_addr_q, ld_addr_d;
  logic            lsq_valid_q, lsq_valid_d;
  logic [XLEN-1:0] lsq_value_q, lsq_value_d;

  logic             drain_ready;
  logic             drain_free;
  logic             load_try;
  logic             ld_unknown;
  logic             ld_hit;
  logic [IDX_W-1:0] ld_lim;
  logic [IDX_W-1:0] scan_idx;
`ifdef SQ_FORWARD_EN
  logic [IDX_W-1:0] ld_hit_idx;
`endif
  logic [CNT_W-1:0] squashed_n;

  assign sq_tail     = tail_q;
  assign sq_full     = (count_q == FULL_CNT);
  assign lsq_valid   = lsq_valid_q;
  assign lsq_value   = lsq_value_q;
  assign drain_ready = valid_q[head_q] & committed_q[head_q] & addr_valid_q[head_q];
  assign load_try    = fu_valid & fu_load & ~lsq_valid_q & ~squash;

  // Scan the stores older than the load (head-relative offsets handle wrap);
  // the last match seen in offset order is the youngest older store.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    ld_unknown = 1'b0;
    ld_hit     = 1'b0;
    scan_idx   = '0;
`ifdef SQ_FORWARD_EN
    ld_hit_idx = '0;
`endif
    ld_lim     = fu_sq_pos - head_q;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      scan_idx = head_q + IDX_W'(k);
      if ((IDX_W'(k) < ld_lim) && valid_q[scan_idx]) begin
        if (!addr_valid_q[scan_idx]) begin
          ld_unknown = 1'b1;
        end else if (addr_q[scan_idx] == fu_addr) begin
          ld_hit     = 1'b1;
`ifdef SQ_FORWARD_EN
          ld_hit_idx = scan_idx;
`endif
        end
      end
    end
  end

  // Memory-port FSM: store drain has priority, then load service; squash drops loads.
  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    lsq_valid_d = 1'b0;
    lsq_value_d = lsq_value_q;
    drain_free  = 1'b0;
    mem_req     = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (drain_ready) begin
          state_d = S_ST_REQ;
        end else if (load_try && !ld_unknown) begin
          if (!ld_hit) begin
            state_d   = S_LD_REQ;
            ld_addr_d = fu_addr;
          end
`ifdef SQ_FORWARD_EN
          else begin
            lsq_valid_d = 1'b1;
            lsq_value_d = data_q[ld_hit_idx];
          end
`endif
        end
      end
      S_ST_REQ: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
        if (mem_grant) begin
          drain_free = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_LD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = ld_addr_q;
        if (squash) begin
          state_d = mem_grant ? S_DROP : S_IDLE;
        end else if (mem_grant) begin
          state_d = S_LD_WAIT;
        end
      end
      S_LD_WAIT: begin
        if (squash) begin
          state_d = mem_rvalid ? S_IDLE : S_DROP;
        end else if (mem_rvalid) begin
          lsq_valid_d = 1'b1;
          lsq_value_d = mem_rdata;
          state_d     = S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry bookkeeping: drain free, store capture, commit, then squash or allocate.
  always_comb begin
    valid_d      = valid_q;
    addr_valid_d = addr_valid_q;
    committed_d  = committed_q;
    addr_d       = addr_q;
    data_d       = data_q;
    head_d       = head_q;
    commit_d     = commit_q;
    tail_d       = tail_q;
    count_d      = count_q;
    squashed_n   = '0;

    if (drain_free) begin
      valid_d[head_q]      = 1'b0;
      addr_valid_d[head_q] = 1'b0;
      committed_d[head_q]  = 1'b0;
      head_d               = head_q + IDX_W'(1);
      count_d              = count_d - CNT_W'(1);
    end

    // A held store request may still be presented while its entry drains; ignore it then.
    if (fu_valid && fu_store && valid_q[fu_sq_pos] && !(drain_free && (fu_sq_pos == head_q))) begin
      addr_d[fu_sq_pos]       = fu_addr;
      data_d[fu_sq_pos]       = fu_value;
      addr_valid_d[fu_sq_pos] = 1'b1;
    end

    if (commit_store) begin
      committed_d[commit_q] = 1'b1;
      commit_d              = commit_q + IDX_W'(1);
    end

    if (squash) begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (valid_d[i] && !committed_d[i]) begin
          valid_d[i]      = 1'b0;
          addr_valid_d[i] = 1'b0;
          squashed_n      = squashed_n + CNT_W'(1);
        end
      end
      tail_d  = commit_d;
      count_d = count_d - squashed_n;
    end else if (dispatch_en && !sq_full) begin
      valid_d[tail_q]      = 1'b1;
      addr_valid_d[tail_q] = 1'b0;
      committed_d[tail_q]  = 1'b0;
      tail_d               = tail_q + IDX_W'(1);
      count_d              = count_d + CNT_W'(1);
    end
  end

  // Control state, pointers and entry flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      commit_q     <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      addr_valid_q <= '0;
      committed_q  <= '0;
      ld_addr_q    <= '0;
      lsq_valid_q  <= 1'b0;
      lsq_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      commit_q     <= commit_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      addr_valid_q <= addr_valid_d;
      committed_q  <= committed_d;
      ld_addr_q    <= ld_addr_d;
      lsq_valid_q  <= lsq_valid_d;
      lsq_value_q  <= lsq_value_d;
    end
  end

  // Entry address/data storage.
  // NOTE: payload arrays are not reset; they are only read once the valid/addr_valid flags say so.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
